// File: rtl/ctl_perf_sampler.sv
// ctl_perf_sampler: sweeps masked perf counters through a shared read port into a 4-deep sample FIFO
module ctl_perf_sampler #(
  parameter int N_LOG    = 5,
  parameter int PER_W    = 16,
  parameter int FIFO_LOG = 2
) (
  input  logic                  clk_ni,
  input  logic                  rst_ni,
  input  logic                  i_enable,
  input  logic [PER_W-1:0]      i_period,
  input  logic                  i_trigger,
  input  logic [(1<<N_LOG)-1:0] i_mask,
  input  logic                  i_ovr_clr,
  output logic                  o_rd_req,
  output logic [N_LOG-1:0]      o_rd_adr,
  input  logic                  i_rd_gnt,
  input  logic [15:0]           i_rd_data,
  output logic                  o_smp_valid,
  output logic [N_LOG-1:0]      o_smp_adr,
  output logic [15:0]           o_smp_data,
  output logic                  o_smp_last,
  input  logic                  i_smp_stall,
  output logic                  o_busy,
  output logic                  o_overrun,
  output logic [7:0]            o_seq
);
  localparam int N     = 1 << N_LOG;
  localparam int DEPTH = 1 << FIFO_LOG;
  localparam int CW    = FIFO_LOG + 1;
  localparam int EW    = N_LOG + 17;
  typedef enum logic [1:0] {IDLE, REQ, CAPT} state_t;
  state_t              state_q, state_d;
  logic [PER_W-1:0]    tmr_q, tmr_d;
  logic [N-1:0]        mask_q, mask_d, above;
  logic [N_LOG-1:0]    idx_q, idx_d, first_idx, next_idx;
  logic [7:0]          seq_q, seq_d;
  logic                ovr_q, ovr_d;
  logic [FIFO_LOG-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [EW-1:0]       mem_q [DEPTH];
  logic                run, tick, start, accept, last, push, pop;
  always_comb begin
    run    = i_enable && (i_period != '0);
    tick   = run && (tmr_q >= i_period - PER_W'(1));
    tmr_d  = !run ? tmr_q : tick ? '0 : tmr_q + PER_W'(1);
    start  = (tick || i_trigger) && i_enable;
    accept = (state_q == IDLE) && start && (i_mask != '0);
    ovr_d  = (start && o_busy) || (ovr_q && !i_ovr_clr);
  end
  // above holds latched-mask bits strictly higher than the current index
  always_comb begin
    first_idx = '0;
    next_idx  = '0;
    above     = mask_q & ~((N'(2) << idx_q) - N'(1));
    for (int k = N - 1; k >= 0; k--) begin
      first_idx = i_mask[k] ? N_LOG'(k) : first_idx;
      next_idx  = above[k] ? N_LOG'(k) : next_idx;
    end
    last = (above == '0);
  end
  always_ff @(posedge clk_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end
  always_comb begin
    state_d = accept ? REQ :
              (state_q == REQ && o_rd_req && i_rd_gnt) ? CAPT :
              (state_q == CAPT) ? (last ? IDLE : REQ) : state_q;
  end
  // a request is only raised while a FIFO slot is free for its capture
  always_comb begin
    o_busy      = state_q != IDLE;
    o_rd_req    = (state_q == REQ) && !cnt_q[FIFO_LOG];
    o_rd_adr    = idx_q;
    push        = state_q == CAPT;
    o_smp_valid = cnt_q != '0;
    {o_smp_adr, o_smp_data, o_smp_last} = o_smp_valid ? mem_q[rp_q] : '0;
    o_overrun   = ovr_q;
    o_seq       = seq_q;
  end
  always_comb begin
    pop    = o_smp_valid && !i_smp_stall;
    mask_d = accept ? i_mask : mask_q;
    idx_d  = accept ? first_idx : (push && !last) ? next_idx : idx_q;
    seq_d  = seq_q + 8'(push && last);
    wp_d   = wp_q + FIFO_LOG'(push);
    rp_d   = rp_q + FIFO_LOG'(pop);
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk_ni) begin
    if (!rst_ni) begin
      tmr_q  <= '0;
      mask_q <= '0;
      idx_q  <= '0;
      seq_q  <= '0;
      ovr_q  <= 1'b0;
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
    end else begin
      tmr_q  <= tmr_d;
      mask_q <= mask_d;
      idx_q  <= idx_d;
      seq_q  <= seq_d;
      ovr_q  <= ovr_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
    end
  end
  always_ff @(posedge clk_ni) begin
    if (push) mem_q[wp_q] <= {idx_q, i_rd_data, last};
  end
endmodule

// File: tb/tb_ctl_perf_sampler.sv
// tb_ctl_perf_sampler: directed scenario bench with a counter-bank model and a sample-stream monitor
module tb_ctl_perf_sampler;
  logic        clk_ni = 1'b0, rst_ni = 1'b0, i_enable = 1'b0, i_trigger = 1'b0, i_ovr_clr = 1'b0;
  logic        i_rd_gnt = 1'b0, i_smp_stall = 1'b0;
  logic [15:0] i_period = '0, i_rd_data = '0;
  logic [31:0] i_mask = '0;
  logic        o_rd_req, o_smp_valid, o_smp_last, o_busy, o_overrun;
  logic [4:0]  o_rd_adr, o_smp_adr;
  logic [15:0] o_smp_data;
  logic [7:0]  o_seq;
  int          errs = 0, checks = 0, cyc = 0, gnt_delay = 0, dly = 0, gnt_cnt = 0, exp_seq = 0;
  logic        g_q = 1'b0;
  logic [4:0]  a_q = '0;
  logic [21:0] sq [$];

  ctl_perf_sampler dut (
    .clk_ni(clk_ni), .rst_ni(rst_ni), .i_enable(i_enable), .i_period(i_period),
    .i_trigger(i_trigger), .i_mask(i_mask), .i_ovr_clr(i_ovr_clr), .o_rd_req(o_rd_req),
    .o_rd_adr(o_rd_adr), .i_rd_gnt(i_rd_gnt), .i_rd_data(i_rd_data), .o_smp_valid(o_smp_valid),
    .o_smp_adr(o_smp_adr), .o_smp_data(o_smp_data), .o_smp_last(o_smp_last),
    .i_smp_stall(i_smp_stall), .o_busy(o_busy), .o_overrun(o_overrun), .o_seq(o_seq)
  );

  always #5 clk_ni = ~clk_ni;
  always @(posedge clk_ni) cyc++;

  // counter bank: grants after gnt_delay waiting cycles, data = A000|adr the cycle after grant
  always @(negedge clk_ni) begin
    i_rd_data = g_q ? (16'hA000 | {11'd0, a_q}) : 16'h0;
    if (o_rd_req && dly >= gnt_delay) begin
      i_rd_gnt = 1'b1;
      dly = 0;
      gnt_cnt++;
    end else begin
      i_rd_gnt = 1'b0;
      dly = o_rd_req ? dly + 1 : 0;
    end
    g_q = i_rd_gnt;
    a_q = o_rd_adr;
    if (rst_ni && o_smp_valid && !i_smp_stall) sq.push_back({o_smp_adr, o_smp_data, o_smp_last});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_ni);
    #1;
  endtask

  task automatic wait_rise(output int t);
    logic p;
    p = o_busy;
    t = -1;
    for (int i = 0; i < 40 && t < 0; i++) begin
      @(posedge clk_ni);
      #1;
      if (o_busy && !p) t = cyc;
      p = o_busy;
    end
    checks++;
    if (t < 0) begin
      errs++;
      $display("FAIL busy_rise: got no rise in 40 cycles want a sweep start");
    end
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    step(2);
    checks += 5;
    if (o_rd_req !== 1'b0)    begin errs++; $display("FAIL reset_req: got %b want 0", o_rd_req); end
    if (o_smp_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", o_smp_valid); end
    if (o_busy !== 1'b0)      begin errs++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    if (o_overrun !== 1'b0)   begin errs++; $display("FAIL reset_ovr: got %b want 0", o_overrun); end
    if (o_seq !== 8'd0)       begin errs++; $display("FAIL reset_seq: got %0d want 0", o_seq); end
    rst_ni = 1'b1;
    step(1);
  endtask

  task automatic test_period;
    int t0, t1;
    logic [21:0] got, exp;
    sq.delete();
    gnt_delay = 0;
    i_mask = 32'h5;
    i_period = 16'd8;
    i_enable = 1'b1;
    wait_rise(t0);
    wait_rise(t1);
    i_enable = 1'b0;
    checks += 2;
    if (t1 - t0 !== 8) begin errs++; $display("FAIL period_interval: got %0d want 8", t1 - t0); end
    exp_seq = 1;
    if (o_seq !== 8'(exp_seq)) begin errs++; $display("FAIL period_seq1: got %0d want %0d", o_seq, exp_seq); end
    step(10);
    exp_seq = 2;
    checks += 3;
    if (o_seq !== 8'(exp_seq)) begin errs++; $display("FAIL period_seq2: got %0d want %0d", o_seq, exp_seq); end
    if (o_busy !== 1'b0) begin errs++; $display("FAIL period_idle: got %b want 0", o_busy); end
    if (sq.size() !== 4) begin errs++; $display("FAIL period_count: got %0d want 4", sq.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < sq.size()) ? sq[i] : 'x;
      exp = (i % 2 == 0) ? {5'd0, 16'hA000, 1'b0} : {5'd2, 16'hA002, 1'b1};
      checks++;
      if (got !== exp) begin errs++; $display("FAIL period_smp%0d: got %h want %h", i, got, exp); end
    end
    i_period = '0;
  endtask

  task automatic test_delay;
    int n0, n31;
    logic [21:0] got, exp;
    sq.delete();
    gnt_delay = 5;
    i_mask = 32'h8000_0001;
    i_enable = 1'b1;
    i_trigger = 1'b1;
    step(1);
    i_trigger = 1'b0;
    n0 = 0;
    n31 = 0;
    for (int i = 0; i < 30; i++) begin
      if (o_rd_req && o_rd_adr == 5'd0) n0++;
      if (o_rd_req && o_rd_adr == 5'd31) n31++;
      step(1);
    end
    exp_seq = 3;
    checks += 5;
    if (n0 !== 6)  begin errs++; $display("FAIL delay_hold0: got %0d want 6", n0); end
    if (n31 !== 6) begin errs++; $display("FAIL delay_hold31: got %0d want 6", n31); end
    if (o_busy !== 1'b0) begin errs++; $display("FAIL delay_idle: got %b want 0", o_busy); end
    if (o_seq !== 8'(exp_seq)) begin errs++; $display("FAIL delay_seq: got %0d want %0d", o_seq, exp_seq); end
    if (sq.size() !== 2) begin errs++; $display("FAIL delay_count: got %0d want 2", sq.size()); end
    for (int i = 0; i < 2; i++) begin
      got = (i < sq.size()) ? sq[i] : 'x;
      exp = (i == 0) ? {5'd0, 16'hA000, 1'b0} : {5'd31, 16'hA01F, 1'b1};
      checks++;
      if (got !== exp) begin errs++; $display("FAIL delay_smp%0d: got %h want %h", i, got, exp); end
    end
    gnt_delay = 0;
  endtask

  task automatic test_stall;
    logic [21:0] got, exp;
    sq.delete();
    i_smp_stall = 1'b1;
    gnt_cnt = 0;
    i_mask = 32'hFFFF_FFFF;
    i_trigger = 1'b1;
    step(1);
    i_trigger = 1'b0;
    step(30);
    checks += 6;
    if (gnt_cnt !== 4)       begin errs++; $display("FAIL stall_grants: got %0d want 4", gnt_cnt); end
    if (o_rd_req !== 1'b0)   begin errs++; $display("FAIL stall_req: got %b want 0", o_rd_req); end
    if (o_busy !== 1'b1)     begin errs++; $display("FAIL stall_busy: got %b want 1", o_busy); end
    if (o_smp_valid !== 1'b1) begin errs++; $display("FAIL stall_valid: got %b want 1", o_smp_valid); end
    if (o_smp_adr !== 5'd0)  begin errs++; $display("FAIL stall_head_adr: got %0d want 0", o_smp_adr); end
    if (o_smp_data !== 16'hA000) begin errs++; $display("FAIL stall_head_data: got %h want a000", o_smp_data); end
    i_smp_stall = 1'b0;
    step(120);
    exp_seq = 4;
    checks += 3;
    if (sq.size() !== 32) begin errs++; $display("FAIL stall_count: got %0d want 32", sq.size()); end
    if (o_busy !== 1'b0)  begin errs++; $display("FAIL stall_idle: got %b want 0", o_busy); end
    if (o_seq !== 8'(exp_seq)) begin errs++; $display("FAIL stall_seq: got %0d want %0d", o_seq, exp_seq); end
    for (int i = 0; i < 32; i++) begin
      got = (i < sq.size()) ? sq[i] : 'x;
      exp = {5'(i), 16'hA000 | 16'(i), i == 31};
      checks++;
      if (got !== exp) begin errs++; $display("FAIL stall_smp%0d: got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_overrun;
    int t, n;
    i_mask = 32'hFFFF_FFFF;
    i_period = 16'd4;
    i_enable = 1'b1;
    wait_rise(t);
    step(6);
    checks++;
    if (o_overrun !== 1'b1) begin errs++; $display("FAIL ovr_set: got %b want 1", o_overrun); end
    i_enable = 1'b0;
    i_ovr_clr = 1'b1;
    step(1);
    i_ovr_clr = 1'b0;
    checks++;
    if (o_overrun !== 1'b0) begin errs++; $display("FAIL ovr_clr: got %b want 0", o_overrun); end
    i_enable = 1'b1;
    i_ovr_clr = 1'b1;
    n = 0;
    repeat (8) begin
      step(1);
      if (o_overrun) n++;
    end
    checks++;
    if (n !== 2) begin errs++; $display("FAIL ovr_set_wins: got %0d high cycles want 2", n); end
    i_enable = 1'b0;
    i_period = '0;
    step(1);
    i_ovr_clr = 1'b0;
    checks++;
    if (o_overrun !== 1'b0) begin errs++; $display("FAIL ovr_clr2: got %b want 0", o_overrun); end
    for (int i = 0; i < 200 && o_busy; i++) step(1);
    exp_seq = 5;
    checks += 2;
    if (o_busy !== 1'b0) begin errs++; $display("FAIL ovr_drain: got %b want 0", o_busy); end
    if (o_seq !== 8'(exp_seq)) begin errs++; $display("FAIL ovr_seq: got %0d want %0d", o_seq, exp_seq); end
    step(4);
  endtask

  task automatic test_mask_zero;
    int nb;
    i_mask = '0;
    i_enable = 1'b1;
    i_trigger = 1'b1;
    step(1);
    i_trigger = 1'b0;
    nb = 0;
    repeat (5) begin
      if (o_busy || o_rd_req) nb++;
      step(1);
    end
    checks += 2;
    if (nb !== 0) begin errs++; $display("FAIL mask0_busy: got %0d active cycles want 0", nb); end
    if (o_seq !== 8'(exp_seq)) begin errs++; $display("FAIL mask0_seq: got %0d want %0d", o_seq, exp_seq); end
    i_mask = 32'h1;
    i_enable = 1'b0;
    i_trigger = 1'b1;
    step(1);
    i_trigger = 1'b0;
    nb = 0;
    repeat (5) begin
      if (o_busy || o_rd_req) nb++;
      step(1);
    end
    checks += 3;
    if (nb !== 0) begin errs++; $display("FAIL disabled_busy: got %0d active cycles want 0", nb); end
    if (o_seq !== 8'(exp_seq)) begin errs++; $display("FAIL disabled_seq: got %0d want %0d", o_seq, exp_seq); end
    if (o_overrun !== 1'b0) begin errs++; $display("FAIL disabled_ovr: got %b want 0", o_overrun); end
  endtask

  task automatic test_mid_reset;
    logic found;
    i_mask = 32'hFFFF_FFFF;
    i_enable = 1'b1;
    i_trigger = 1'b1;
    step(1);
    i_trigger = 1'b0;
    step(2);
    i_trigger = 1'b1;
    step(1);
    i_trigger = 1'b0;
    checks++;
    if (o_overrun !== 1'b1) begin errs++; $display("FAIL midrst_pre_ovr: got %b want 1", o_overrun); end
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (o_rd_req && o_rd_adr == 5'd10) found = 1'b1;
      else step(1);
    end
    checks++;
    if (found !== 1'b1) begin errs++; $display("FAIL midrst_reach10: got %b want 1", found); end
    rst_ni = 1'b0;
    step(1);
    checks += 5;
    if (o_rd_req !== 1'b0)    begin errs++; $display("FAIL midrst_req: got %b want 0", o_rd_req); end
    if (o_smp_valid !== 1'b0) begin errs++; $display("FAIL midrst_valid: got %b want 0", o_smp_valid); end
    if (o_seq !== 8'd0)       begin errs++; $display("FAIL midrst_seq: got %0d want 0", o_seq); end
    if (o_overrun !== 1'b0)   begin errs++; $display("FAIL midrst_ovr: got %b want 0", o_overrun); end
    if (o_busy !== 1'b0)      begin errs++; $display("FAIL midrst_busy: got %b want 0", o_busy); end
    i_enable = 1'b0;
    rst_ni = 1'b1;
    step(2);
    checks++;
    if (o_busy !== 1'b0 || o_rd_req !== 1'b0) begin
      errs++;
      $display("FAIL midrst_after: got busy=%b req=%b want 0 0", o_busy, o_rd_req);
    end
  endtask

  initial begin
    test_reset();
    test_period();
    test_delay();
    test_stall();
    test_overrun();
    test_mask_zero();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
